// File: rtl/valu_dot_acc.sv
// ============================================================================
//  Module   : valu_dot_acc
//  Purpose  : Accumulates LEN signed 32-bit dot-product beats onto a bias and
//             returns one ACC_W-bit result through a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module valu_dot_acc #(
   parameter int ACC_W    = 32,
   parameter int LEN_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [ACC_W-1:0] bias_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      dot_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [ACC_W-1:0] acc_o,
   output logic             sat_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [LEN_W-1:0] c_one     = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               sat_q, sat_d;
   logic [LEN_W-1:0]   count_q, count_d;

   logic               w_beat;
   logic [ACC_W:0]     w_sum;
   logic               w_ovf;

   assign w_beat = in_valid_i & (state_q == S_ACCUM);
   // One guard bit: overflow shows up as a disagreement between the two MSBs.
   assign w_sum  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-32){dot_i[31]}}, dot_i};
   assign w_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               acc_d   = bias_i;
               sat_d   = 1'b0;
               count_d = len_i;
               state_d = (len_i != '0) ? S_ACCUM : S_DONE;
            end
         end
         S_ACCUM: begin
            if (w_beat) begin
               count_d = count_q - c_one;
               acc_d   = w_sum[ACC_W-1:0];
               if (w_ovf) begin
                  sat_d = 1'b1;
                  if (SATURATE) begin
                     acc_d = w_sum[ACC_W] ? c_acc_min : c_acc_max;
                  end
               end
               if (count_q == c_one) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         sat_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         count_q <= count_d;
      end
   end

   assign in_ready_o  = (state_q == S_ACCUM);
   assign out_valid_o = (state_q == S_DONE);
   assign busy_o      = (state_q != S_IDLE);
   assign acc_o       = acc_q;
   assign sat_o       = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_valu_dot_acc.sv
// ============================================================================
//  Module   : tb_valu_dot_acc
//  Purpose  : Self-checking bench for valu_dot_acc, saturating and wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_valu_dot_acc;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [15:0] len_i;
   logic [31:0] bias_i;
   logic        in_valid_i;
   logic [31:0] dot_i;
   logic        out_ready_i;

   logic        in_ready_s, out_valid_s, sat_s, busy_s;
   logic [31:0] acc_s;
   logic        in_ready_w, out_valid_w, sat_w, busy_w;
   logic [31:0] acc_w;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_i = ~clk_i;

   valu_dot_acc #(.ACC_W(32), .LEN_W(16), .SATURATE(1'b1)) u_dut_sat (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .bias_i(bias_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_s),
      .dot_i(dot_i), .out_valid_o(out_valid_s), .out_ready_i(out_ready_i),
      .acc_o(acc_s), .sat_o(sat_s), .busy_o(busy_s)
   );

   valu_dot_acc #(.ACC_W(32), .LEN_W(16), .SATURATE(1'b0)) u_dut_wrap (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .bias_i(bias_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_w),
      .dot_i(dot_i), .out_valid_o(out_valid_w), .out_ready_i(out_ready_i),
      .acc_o(acc_w), .sat_o(sat_w), .busy_o(busy_w)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Reference: integer sum with range check after every beat.
   function automatic void model(input logic [31:0] bias, input int dq[$], input bit sat_mode,
                                 output logic [31:0] res, output bit ovf);
      longint a;
      longint s;
      a   = longint'($signed(bias));
      ovf = 1'b0;
      foreach (dq[k]) begin
         s = a + longint'(dq[k]);
         if (s > 64'sd2147483647) begin
            ovf = 1'b1;
            a   = sat_mode ? 64'sd2147483647 : s - 64'sd4294967296;
         end else if (s < -64'sd2147483648) begin
            ovf = 1'b1;
            a   = sat_mode ? -64'sd2147483648 : s + 64'sd4294967296;
         end else begin
            a = s;
         end
      end
      res = a[31:0];
   endfunction

   task automatic check_ctl(input string tag, input logic rdy, input logic vld, input logic bsy);
      check({tag, "_in_ready_s"},  in_ready_s,  rdy);
      check({tag, "_out_valid_s"}, out_valid_s, vld);
      check({tag, "_busy_s"},      busy_s,      bsy);
      check({tag, "_in_ready_w"},  in_ready_w,  rdy);
      check({tag, "_out_valid_w"}, out_valid_w, vld);
      check({tag, "_busy_w"},      busy_w,      bsy);
   endtask

   task automatic check_res(input string tag, input logic [31:0] es, input bit vs,
                            input logic [31:0] ew, input bit vw);
      check({tag, "_acc_s"}, acc_s, es);
      check({tag, "_sat_s"}, sat_s, vs);
      check({tag, "_acc_w"}, acc_w, ew);
      check({tag, "_sat_w"}, sat_w, vw);
   endtask

   task automatic run_job(input string tag, input logic [31:0] bias, input int dq[$],
                          input int gap_min, input int gap_max, input int rdy_dly, input bit poke);
      logic [31:0] es, ew;
      bit          vs, vw;
      model(bias, dq, 1'b1, es, vs);
      model(bias, dq, 1'b0, ew, vw);

      // in_valid_i high with junk during IDLE must not be consumed
      start_i    = 1'b1;
      len_i      = 16'(dq.size());
      bias_i     = bias;
      in_valid_i = 1'b1;
      dot_i      = $urandom;
      tick();
      start_i = 1'b0;
      len_i   = 16'($urandom);
      bias_i  = $urandom;

      foreach (dq[k]) begin
         int g;
         g = $urandom_range(gap_max, gap_min);
         for (int j = 0; j < g; j++) begin
            in_valid_i = 1'b0;
            dot_i      = $urandom;
            start_i    = poke & 1'($urandom_range(1, 0));
            tick();
         end
         start_i = 1'b0;
         check({tag, "_acc_ready_s"}, in_ready_s, 1'b1);
         check({tag, "_acc_ready_w"}, in_ready_w, 1'b1);
         in_valid_i = 1'b1;
         dot_i      = dq[k];
         start_i    = poke;
         tick();
      end

      start_i = 1'b0;
      check_ctl({tag, "_done"}, 1'b0, 1'b1, 1'b1);
      check_res({tag, "_done"}, es, vs, ew, vw);

      for (int j = 0; j < rdy_dly; j++) begin
         in_valid_i  = 1'($urandom_range(1, 0));
         dot_i       = $urandom;
         start_i     = poke;
         out_ready_i = 1'b0;
         tick();
         check({tag, "_stall_valid"}, out_valid_s & out_valid_w, 1'b1);
         check({tag, "_stall_acc_s"}, acc_s, es);
         check({tag, "_stall_acc_w"}, acc_w, ew);
      end

      out_ready_i = 1'b1;
      start_i     = poke;
      in_valid_i  = 1'b1;
      tick();
      out_ready_i = 1'b0;
      start_i     = 1'b0;
      in_valid_i  = 1'b0;
      check_ctl({tag, "_post"}, 1'b0, 1'b0, 1'b0);
      check_res({tag, "_post"}, es, vs, ew, vw);
      tick();
      check({tag, "_idle_busy"}, busy_s | busy_w, 1'b0);
   endtask

   initial begin
      int q[$];
      rst_i       = 1'b1;
      start_i     = 1'b0;
      len_i       = '0;
      bias_i      = '0;
      in_valid_i  = 1'b0;
      dot_i       = '0;
      out_ready_i = 1'b0;
      tick();
      tick();
      check_ctl("reset", 1'b0, 1'b0, 1'b0);
      check_res("reset", 32'h0, 1'b0, 32'h0, 1'b0);
      rst_i = 1'b0;
      tick();

      q = {10, -3, 100, 7};
      run_job("t1", 32'h0, q, 0, 0, 0, 1'b0);
      run_job("t2", 32'h0, q, 1, 3, 5, 1'b0);

      q.delete();
      run_job("t3", 32'hFFFFFFFB, q, 0, 0, 2, 1'b0);

      q = {32'sh20};
      run_job("t4a", 32'h7FFFFFF0, q, 0, 0, 0, 1'b0);
      q = {-1};
      run_job("t4b", 32'h80000000, q, 0, 0, 0, 1'b0);
      q = {int'(32'h7FFFFFFF), int'(32'h7FFFFFFF), -5};
      run_job("t4c", 32'h10, q, 0, 1, 0, 1'b0);

      // Abort after two of four beats
      start_i = 1'b1; len_i = 16'd4; bias_i = 32'd0;
      tick();
      start_i = 1'b0; in_valid_i = 1'b1; dot_i = 32'd5;
      tick();
      dot_i = 32'd6;
      tick();
      in_valid_i = 1'b0; rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_ctl("t5rst", 1'b0, 1'b0, 1'b0);
      check_res("t5rst", 32'h0, 1'b0, 32'h0, 1'b0);
      q = {3};
      run_job("t5", 32'h0, q, 0, 0, 0, 1'b0);

      q = {1, 2, 3, 4, 5};
      run_job("t6", 32'd100, q, 1, 2, 3, 1'b1);

      q.delete();
      for (int k = 0; k < 300; k++) q.push_back(int'($urandom_range(2000, 0)) - 1000);
      run_job("long", $urandom, q, 0, 0, 1, 1'b0);

      for (int r = 0; r < 25; r++) begin
         logic [31:0] b;
         int          n;
         n = $urandom_range(6, 0);
         b = ($urandom_range(2, 0) == 0) ? {1'($urandom_range(1, 0)), 31'h7FFFFF00} + $urandom_range(255, 0)
                                         : $urandom;
         q.delete();
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(1, 0) == 1) q.push_back(int'($urandom));
            else q.push_back(int'($urandom_range(512, 0)) - 256);
         end
         run_job($sformatf("rnd%0d", r), b, q, 0, 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
